// File: rtl/ccm_mic_verify.sv
// Receive-side CCM MIC checker: CBC-MAC over B0 and zero-padded payload blocks,
// then compares the S0-decrypted received tag against the MAC.
module ccm_mic_verify #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned WIDTH_NONCE = 100,
   parameter int unsigned WIDTH_FLAG  = 8,
   parameter int unsigned WIDTH_COUNT = 20,
   parameter int unsigned WIDTH_TAG   = 64,
   localparam int unsigned WIDTH_BLK  = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH_BLK-1:0]   ccm_b0,
   input  logic [WIDTH_BLK-1:0]   key_aes,
   input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
   input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
   input  logic [WIDTH-1:0]       input_data,
   input  logic                   input_en,
   input  logic                   input_last,
   input  logic [WIDTH-1:0]       tag_data,
   input  logic                   tag_en,
   output logic                   busy,
   output logic                   mic_valid,
   output logic                   mic_ok
);

   localparam int unsigned TagBytes = WIDTH_TAG / 8;
   localparam logic [4:0]  TagLast  = 5'(TagBytes - 1);

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StPad,
      StTag,
      StCheck
   } state_e;

   state_e                   state_q, state_d;
   logic [WIDTH_BLK-1:0]     mac_q, mac_d;
   logic [WIDTH_BLK-WIDTH-1:0] blk_q, blk_d;
   logic [WIDTH_TAG-1:0]     tagbuf_q, tagbuf_d;
   logic [3:0]               byte_cnt_q, byte_cnt_d;
   logic [4:0]               tag_cnt_q, tag_cnt_d;
   logic                     mic_valid_q, mic_valid_d;
   logic                     mic_ok_q, mic_ok_d;

   logic [WIDTH_BLK-1:0]     blk_data;
   logic [WIDTH_BLK-1:0]     blk_zero;
   logic [WIDTH_BLK-1:0]     s0;

   assign blk_data = {blk_q, input_data};
   assign blk_zero = {blk_q, {WIDTH{1'b0}}};
   // Cipher E(x) = x ^ key_aes applied to A0 (counter field zero).
   assign s0 = {ccm_ctr_flag, ccm_ctr_nonce, {WIDTH_COUNT{1'b0}}} ^ key_aes;

   if (WIDTH_TAG < WIDTH_BLK) begin : g_s0_lo
      logic unused_s0_lo;
      assign unused_s0_lo = ^s0[WIDTH_BLK-WIDTH_TAG-1:0];
   end

   always_comb begin
      state_d     = state_q;
      mac_d       = mac_q;
      blk_d       = blk_q;
      tagbuf_d    = tagbuf_q;
      byte_cnt_d  = byte_cnt_q;
      tag_cnt_d   = tag_cnt_q;
      mic_valid_d = 1'b0;
      mic_ok_d    = mic_ok_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               mac_d      = ccm_b0 ^ key_aes;
               byte_cnt_d = 4'd0;
               tag_cnt_d  = 5'd0;
               mic_ok_d   = 1'b0;
               state_d    = StData;
            end
         end
         StData: begin
            if (input_en) begin
               blk_d      = blk_data[WIDTH_BLK-WIDTH-1:0];
               byte_cnt_d = byte_cnt_q + 4'd1;
               // Fold on the 16th byte using the just-completed block.
               if (byte_cnt_q == 4'd15) begin
                  mac_d = (mac_q ^ blk_data) ^ key_aes;
               end
               if (input_last) begin
                  state_d = (byte_cnt_q == 4'd15) ? StTag : StPad;
               end
            end
         end
         StPad: begin
            blk_d      = blk_zero[WIDTH_BLK-WIDTH-1:0];
            byte_cnt_d = byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
               mac_d   = (mac_q ^ blk_zero) ^ key_aes;
               state_d = StTag;
            end
         end
         StTag: begin
            if (tag_en) begin
               tagbuf_d  = {tagbuf_q[WIDTH_TAG-WIDTH-1:0], tag_data};
               tag_cnt_d = tag_cnt_q + 5'd1;
               if (tag_cnt_q == TagLast) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            mic_ok_d    = ((tagbuf_q ^ s0[WIDTH_BLK-1:WIDTH_BLK-WIDTH_TAG]) ==
                           mac_q[WIDTH_BLK-1:WIDTH_BLK-WIDTH_TAG]);
            mic_valid_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         mac_q       <= '0;
         blk_q       <= '0;
         tagbuf_q    <= '0;
         byte_cnt_q  <= '0;
         tag_cnt_q   <= '0;
         mic_valid_q <= 1'b0;
         mic_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mac_q       <= mac_d;
         blk_q       <= blk_d;
         tagbuf_q    <= tagbuf_d;
         byte_cnt_q  <= byte_cnt_d;
         tag_cnt_q   <= tag_cnt_d;
         mic_valid_q <= mic_valid_d;
         mic_ok_q    <= mic_ok_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign mic_valid = mic_valid_q;
   assign mic_ok    = mic_ok_q;

endmodule

// File: tb/tb_ccm_mic_verify.sv
// Directed bench for ccm_mic_verify: hand-computed tags, exact verdict timing,
// ignored-input and mid-message reset scenarios.
module tb_ccm_mic_verify;

   localparam int unsigned WIDTH       = 8;
   localparam int unsigned WIDTH_NONCE = 100;
   localparam int unsigned WIDTH_FLAG  = 8;
   localparam int unsigned WIDTH_COUNT = 20;
   localparam int unsigned WIDTH_TAG   = 64;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   start = 1'b0;
   logic [127:0]           ccm_b0 = '0;
   logic [127:0]           key_aes = '0;
   logic [WIDTH_NONCE-1:0] ccm_ctr_nonce = '0;
   logic [WIDTH_FLAG-1:0]  ccm_ctr_flag = '0;
   logic [WIDTH-1:0]       input_data = '0;
   logic                   input_en = 1'b0;
   logic                   input_last = 1'b0;
   logic [WIDTH-1:0]       tag_data = '0;
   logic                   tag_en = 1'b0;
   logic                   busy;
   logic                   mic_valid;
   logic                   mic_ok;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ccm_mic_verify #(
      .WIDTH       (WIDTH),
      .WIDTH_NONCE (WIDTH_NONCE),
      .WIDTH_FLAG  (WIDTH_FLAG),
      .WIDTH_COUNT (WIDTH_COUNT),
      .WIDTH_TAG   (WIDTH_TAG)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .ccm_b0        (ccm_b0),
      .key_aes       (key_aes),
      .ccm_ctr_nonce (ccm_ctr_nonce),
      .ccm_ctr_flag  (ccm_ctr_flag),
      .input_data    (input_data),
      .input_en      (input_en),
      .input_last    (input_last),
      .tag_data      (tag_data),
      .tag_en        (tag_en),
      .busy          (busy),
      .mic_valid     (mic_valid),
      .mic_ok        (mic_ok)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // All stimulus is applied at negedges; each task returns on a negedge.
   task automatic do_start(input logic [127:0] b0);
      ccm_b0 = b0;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      input_en   = 1'b1;
      input_data = d;
      input_last = last;
      @(negedge clk);
      input_en   = 1'b0;
      input_last = 1'b0;
      input_data = '0;
   endtask

   task automatic pad_cycles(input int n, input logic junk);
      for (int i = 0; i < n; i++) begin
         input_en   = junk;
         input_last = junk;
         input_data = 8'h5c;
         @(negedge clk);
      end
      input_en   = 1'b0;
      input_last = 1'b0;
      input_data = '0;
   endtask

   task automatic bogus_tag();
      tag_en   = 1'b1;
      tag_data = 8'h77;
      @(negedge clk);
      tag_en   = 1'b0;
   endtask

   task automatic send_tag(input logic [63:0] t, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         tag_en   = 1'b1;
         tag_data = t[63-8*i -: 8];
         @(negedge clk);
      end
      tag_en   = 1'b0;
      tag_data = '0;
   endtask

   // Called on the negedge after the last tag edge; returns with mic_valid high.
   task automatic expect_verdict(input string tag, input logic ok);
      check({tag, "_check_valid"}, mic_valid, 1'b0);
      check({tag, "_check_busy"}, busy, 1'b1);
      @(negedge clk);
      check({tag, "_valid"}, mic_valid, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_ok"}, mic_ok, ok);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_valid;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", mic_valid, 1'b0);
      check("rst_ok", mic_ok, 1'b0);

      // Single full block, no padding; tag_en on the last data byte is ignored
      do_start('0);
      check("t1_busy", busy, 1'b1);
      for (int i = 1; i <= 15; i++) send_byte(8'(i), 1'b0);
      tag_en   = 1'b1;
      tag_data = 8'hee;
      send_byte(8'h10, 1'b1);
      tag_en   = 1'b0;
      send_tag(64'h0102030405060708, 0, 8);
      expect_verdict("t1", 1'b1);
      @(negedge clk);
      check("t1_valid_drop", mic_valid, 1'b0);
      check("t1_ok_hold", mic_ok, 1'b1);

      // Short payload: exactly 15 PAD cycles; input_en during PAD ignored
      do_start('0);
      send_byte(8'hab, 1'b1);
      pad_cycles(14, 1'b1);
      bogus_tag();
      send_tag(64'hab00000000000000, 0, 8);
      expect_verdict("t2a", 1'b1);
      // start accepted while mic_valid is high clears mic_ok
      do_start('0);
      check("t2_restart_ok", mic_ok, 1'b0);
      check("t2_restart_busy", busy, 1'b1);
      check("t2_restart_valid", mic_valid, 1'b0);
      send_byte(8'hab, 1'b1);
      pad_cycles(15, 1'b0);
      send_tag(64'hab00000000000001, 0, 8);
      expect_verdict("t2b", 1'b0);
      @(negedge clk);

      // All-ones key: MAC folds to zero, S0 is all-ones
      key_aes = '1;
      do_start('0);
      for (int i = 0; i < 16; i++) send_byte(8'h00, i == 15);
      send_tag(64'hffffffffffffffff, 0, 8);
      expect_verdict("t3", 1'b1);
      @(negedge clk);

      // Two blocks with gaps, nonzero B0 and A0; busy-time start/tag_en/input_en ignored
      key_aes       = '0;
      ccm_ctr_flag  = 8'h5a;
      ccm_ctr_nonce = {8'h33, 92'h0};
      do_start({8'h80, 120'h0});
      for (int i = 1; i <= 17; i++) begin
         send_byte(8'(i), i == 17);
         if (i == 5) begin
            do_start({128{1'b1}});
            bogus_tag();
         end
         if (i < 17) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      pad_cycles(14, 1'b1);
      bogus_tag();
      send_tag(64'hca31030405060708, 0, 4);
      input_en   = 1'b1;
      input_last = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      input_en   = 1'b0;
      input_last = 1'b0;
      start      = 1'b0;
      send_tag(64'hca31030405060708, 4, 4);
      expect_verdict("t4", 1'b1);
      @(negedge clk);

      // Reset during TAG aborts with no verdict
      ccm_ctr_flag  = '0;
      ccm_ctr_nonce = '0;
      do_start('0);
      for (int i = 1; i <= 16; i++) send_byte(8'(i), i == 16);
      send_tag(64'h0102030405060708, 0, 3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_busy", busy, 1'b0);
      check("t5_valid", mic_valid, 1'b0);
      check("t5_ok", mic_ok, 1'b0);
      seen_valid = 1'b0;
      for (int i = 3; i < 8; i++) begin
         tag_en   = 1'b1;
         tag_data = 8'(i + 1);
         @(negedge clk);
         seen_valid = seen_valid | mic_valid | busy;
      end
      tag_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen_valid = seen_valid | mic_valid | busy;
      end
      check("t5_no_verdict", seen_valid, 1'b0);

      // Fresh message after reset
      do_start('0);
      for (int i = 1; i <= 16; i++) send_byte(8'(i), i == 16);
      send_tag(64'h0102030405060708, 0, 8);
      expect_verdict("t6", 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_rst_ok", mic_ok, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
